// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus blocks (reader and write executor).
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_STATUS = 2'd0,
    OP_DATA   = 2'd1,
    OP_POLL   = 2'd2,
    OP_RSVD   = 2'd3
  } lcd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HIGH = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } lcd_state_e;

  // Bus timing in 50 MHz clock cycles.
  localparam int          DEF_T_AS     = 3;
  localparam int          DEF_T_PW     = 13;
  localparam int          DEF_T_GAP    = 13;
  localparam logic [15:0] DEF_POLL_MAX = 16'd4100;
  localparam int          TMR_W        = 16;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Load/count-down phase timer; done is high while the count sits at zero.
module lcd_cycle_timer
  import lcd_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// LCD bus read sequencer: status read, data read and busy-flag polling with timeout.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int          T_AS     = DEF_T_AS,
  parameter int          T_PW     = DEF_T_PW,
  parameter int          T_GAP    = DEF_T_GAP,
  parameter logic [15:0] POLL_MAX = DEF_POLL_MAX
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] OP,
  output logic       RDY,
  output logic [7:0] DOUT,
  output logic       BF,
  output logic [6:0] AC,
  output logic       VALID,
  output logic       TIMEOUT,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  input  logic [7:0] LCD_DB_IN,
  output logic       BUS_OWN
);

  localparam logic [TMR_W-1:0] LD_AS  = TMR_W'(T_AS - 1);
  localparam logic [TMR_W-1:0] LD_PW  = TMR_W'(T_PW - 1);
  localparam logic [TMR_W-1:0] LD_GAP = TMR_W'(T_GAP - 1);

  lcd_state_e       state_q, state_d;
  lcd_op_e          op_q, op_d;
  logic [15:0]      poll_q, poll_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       dout_q, dout_d;
  logic             bf_q, bf_d;
  logic [6:0]       ac_q, ac_d;
  logic             to_q, to_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic             last_poll;

  lcd_cycle_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // poll_q counts reads already retried, so the read just finished is number poll_q+1.
  assign last_poll = ({1'b0, poll_q} + 17'd1) >= {1'b0, POLL_MAX};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_STATUS;
      poll_q  <= '0;
      cap_q   <= '0;
      dout_q  <= '0;
      bf_q    <= 1'b0;
      ac_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      poll_q  <= poll_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
      bf_q    <= bf_d;
      ac_q    <= ac_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    poll_d   = poll_q;
    cap_d    = cap_q;
    dout_d   = dout_q;
    bf_d     = bf_q;
    ac_d     = ac_q;
    to_d     = to_q;
    tmr_load = 1'b0;
    tmr_val  = LD_AS;
    unique case (state_q)
      ST_IDLE: begin
        if (START && lcd_op_e'(OP) != OP_RSVD) begin
          op_d     = lcd_op_e'(OP);
          poll_d   = '0;
          to_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = LD_PW;
          state_d  = ST_E_HIGH;
        end
      end
      ST_E_HIGH: begin
        if (tmr_done) begin
          cap_d    = LCD_DB_IN;
          tmr_load = 1'b1;
          tmr_val  = LD_GAP;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          if (op_q != OP_POLL || !cap_q[7] || last_poll) begin
            dout_d  = cap_q;
            to_d    = (op_q == OP_POLL) && cap_q[7];
            state_d = ST_DONE;
            if (op_q != OP_DATA) begin
              bf_d = cap_q[7];
              ac_d = cap_q[6:0];
            end
          end else begin
            poll_d   = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
            tmr_load = 1'b1;
            tmr_val  = LD_AS;
            state_d  = ST_SETUP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins decode straight from the state so reset drops them without a clock edge.
  always_comb begin
    RDY     = (state_q == ST_IDLE);
    BUS_OWN = (state_q == ST_SETUP) || (state_q == ST_E_HIGH) || (state_q == ST_GAP);
    LCD_E   = (state_q == ST_E_HIGH);
    LCD_RW  = BUS_OWN;
    LCD_RS  = BUS_OWN && (op_q == OP_DATA);
    VALID   = (state_q == ST_DONE) && !to_q;
    TIMEOUT = (state_q == ST_DONE) && to_q;
  end

  assign DOUT = dout_q;
  assign BF   = bf_q;
  assign AC   = ac_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: directed scenarios plus randomized reads vs. a transaction-level model.
module tb_lcd_reader;
  import lcd_pkg::*;

  localparam int          T_AS     = 3;
  localparam int          T_PW     = 13;
  localparam int          T_GAP    = 13;
  localparam logic [15:0] POLL_MAX = 16'd4;
  localparam int          CYC      = T_AS + T_PW + T_GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] db = 8'h00;
  logic       rdy, bf, valid, timeout, lcd_rs, lcd_rw, lcd_e, bus_own;
  logic [7:0] dout;
  logic [6:0] ac;

  int total = 0;
  int bad = 0;

  logic [7:0] db_seq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_bf = 1'b0;
  logic [6:0] m_ac = 7'h00;

  lcd_reader #(
    .T_AS(T_AS), .T_PW(T_PW), .T_GAP(T_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .CLK(clk), .RST(rst_n), .START(start), .OP(op), .RDY(rdy), .DOUT(dout),
    .BF(bf), .AC(ac), .VALID(valid), .TIMEOUT(timeout), .LCD_RS(lcd_rs),
    .LCD_RW(lcd_rw), .LCD_E(lcd_e), .LCD_DB_IN(db), .BUS_OWN(bus_own)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RW must never fall while E is high or together with E falling (reset excluded).
  logic prev_rw = 1'b0, prev_e = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (prev_rst && rst_n && prev_rw && !lcd_rw)
      check("rw_fall_vs_e", 32'(prev_e | lcd_e), 32'd0);
    prev_rw  = lcd_rw;
    prev_e   = lcd_e;
    prev_rst = rst_n;
  end

  function automatic logic [7:0] byte_at(int i);
    if (i >= db_seq.size()) i = db_seq.size() - 1;
    return db_seq[i];
  endfunction

  task automatic run_read(input logic [1:0] o, input bit inject, input string tag);
    int         reads, pulses, ehigh, pin_bad, cyc;
    bit         to, seen, e_last;
    logic [7:0] b;
    // Model: one read, or for a poll as many reads as it takes to see BF=0, capped at POLL_MAX.
    reads = 1;
    b = byte_at(0);
    while (o == 2'd2 && b[7] && reads < int'(POLL_MAX)) begin
      reads++;
      b = byte_at(reads - 1);
    end
    to = (o == 2'd2) && b[7];
    m_dout = b;
    if (o != 2'd1) begin
      m_bf = b[7];
      m_ac = b[6:0];
    end

    @(negedge clk);
    start = 1'b1;
    op = o;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0; ehigh = 0; pin_bad = 0; seen = 0; e_last = 0;
    for (cyc = 1; cyc <= 600; cyc++) begin
      @(posedge clk);
      #1;
      start = (inject && cyc >= 2 && cyc <= CYC - 2 && $urandom_range(0, 3) == 0);
      if (lcd_e && !e_last) begin
        pulses++;
        db = byte_at(pulses - 1);
      end
      e_last = lcd_e;
      if (lcd_e) ehigh++;
      if (bus_own && (lcd_rs !== (o == 2'd1) || lcd_rw !== 1'b1)) pin_bad++;
      if (valid || timeout) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_completed"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc + 1), 32'(reads * CYC + 1));
    check({tag, "_e_pulses"}, 32'(pulses), 32'(reads));
    check({tag, "_e_high_cycles"}, 32'(ehigh), 32'(reads * T_PW));
    check({tag, "_rs_rw_pins"}, 32'(pin_bad), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'(!to));
    check({tag, "_timeout"}, 32'(timeout), 32'(to));
    check({tag, "_dout"}, 32'(dout), 32'(m_dout));
    check({tag, "_bf"}, 32'(bf), 32'(m_bf));
    check({tag, "_ac"}, 32'(ac), 32'(m_ac));
    @(posedge clk);
    #1;
    check({tag, "_rdy_after"}, 32'(rdy), 32'd1);
    check({tag, "_pulse_width"}, 32'(valid | timeout), 32'd0);
  endtask

  initial begin
    int cnt;
    #1;
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_pins", {28'd0, lcd_e, lcd_rw, lcd_rs, bus_own}, 32'd0);
    check("reset_outs", {14'd0, dout, bf, ac, valid, timeout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    db_seq = '{8'h25};
    run_read(2'd0, 1'b0, "status");
    db_seq = '{8'h41};
    run_read(2'd1, 1'b0, "data");
    db_seq = '{8'h80, 8'h80, 8'h10};
    run_read(2'd2, 1'b0, "poll_ok");
    db_seq = '{8'hFF};
    run_read(2'd2, 1'b0, "poll_timeout");
    db_seq = '{8'h3C};
    run_read(2'd0, 1'b1, "busy_starts");

    // Reserved op must leave everything idle.
    @(negedge clk);
    start = 1'b1;
    op = 2'd3;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (!rdy || lcd_e || lcd_rw || lcd_rs || bus_own || valid) cnt++;
    end
    check("op3_ignored", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of E high.
    db_seq = '{8'h99};
    db = 8'h99;
    @(negedge clk);
    start = 1'b1;
    op = 2'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_e_before", 32'(lcd_e), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_pins", {29'd0, lcd_e, lcd_rw, bus_own}, 32'd0);
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_outs", {16'd0, dout, bf, ac}, 32'd0);
    m_dout = 8'h00;
    m_bf = 1'b0;
    m_ac = 7'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid || timeout || bus_own) cnt++;
    end
    check("midrst_no_pulse", 32'(cnt), 32'd0);
    db_seq = '{8'h07};
    run_read(2'd0, 1'b0, "after_rst");

    for (int n = 0; n < 20; n++) begin
      logic [1:0] o;
      int len;
      o = 2'($urandom_range(0, 2));
      len = $urandom_range(1, 5);
      db_seq.delete();
      for (int k = 0; k < len; k++) db_seq.push_back(8'($urandom_range(0, 255)));
      run_read(o, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
